// File: rtl/fifo_sched_pkg.sv
// Shared constants for the TX FIFO scheduler: status bit positions and drain FSM encoding.
package fifo_sched_pkg;

   localparam int DATA_W      = 8;
   localparam int STAT_EMPTY  = 0;
   localparam int STAT_FULL   = 1;
   localparam int STAT_AFULL  = 2;
   localparam int STAT_AEMPTY = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ      = 3'd1,
      ST_LOAD      = 3'd2,
      ST_START     = 3'd3,
      ST_WAIT_BUSY = 3'd4,
      ST_WAIT_DONE = 3'd5,
      ST_GAP       = 3'd6
   } drain_state_e;

endpackage

// File: rtl/fifo_tx_scheduler_if.sv
// Requester, FIFO and transmitter signals seen by the TX scheduler.
interface fifo_tx_scheduler_if;
   import fifo_sched_pkg::*;

   logic                req0_valid;
   logic                req1_valid;
   logic [DATA_W-1:0]   req0_data;
   logic [DATA_W-1:0]   req1_data;
   logic                req0_ready;
   logic                req1_ready;
   logic                fifo_write;
   logic [DATA_W-1:0]   fifo_wdata;
   logic                fifo_read;
   logic [DATA_W-1:0]   fifo_rdata;
   logic [3:0]          fifo_status;
   logic                enable;
   logic                tx_start;
   logic [DATA_W-1:0]   tx_data;
   logic                tx_busy;
   logic                sched_busy;
   logic [15:0]         tx_count;

   // master is the scheduler; slave is the requesters, FIFO and transmitter around it
   modport master (
      input  req0_valid, req1_valid, req0_data, req1_data, fifo_rdata, fifo_status,
             enable, tx_busy,
      output req0_ready, req1_ready, fifo_write, fifo_wdata, fifo_read, tx_start,
             tx_data, sched_busy, tx_count
   );

   modport slave (
      output req0_valid, req1_valid, req0_data, req1_data, fifo_rdata, fifo_status,
             enable, tx_busy,
      input  req0_ready, req1_ready, fifo_write, fifo_wdata, fifo_read, tx_start,
             tx_data, sched_busy, tx_count
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer moves only when the grant is used.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt    = req;
      if (req == 2'b11) begin
         gnt = last_q ? 2'b01 : 2'b10;
      end
      last_d = last_q;
      if (accept) begin
         last_d = gnt[1];
      end
   end

   // last = 1 out of reset so requester 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fifo_tx_scheduler.sv
// Arbitrates two byte producers onto the TX FIFO write port and drains the FIFO into the UART.
module fifo_tx_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_tx_scheduler_if.master  bus
);

   localparam bit         GAP_EN   = (GAP_CYCLES != 0);
   localparam logic [7:0] GAP_LOAD = GAP_EN ? (8'(GAP_CYCLES) - 8'd1) : 8'd0;

   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] ready;
   logic       wr_block;
   logic       wr_fire;
   logic       wr_prev_q, wr_prev_d;

   assign req = {bus.req1_valid, bus.req0_valid};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .accept (wr_fire),
      .gnt    (gnt)
   );

   // with AFull set a write in the previous cycle blocks this one
   always_comb begin
      wr_block  = bus.fifo_status[STAT_FULL] | (bus.fifo_status[STAT_AFULL] & wr_prev_q);
      ready     = gnt & {2{~wr_block & ~rst}};
      wr_fire   = |ready;
      wr_prev_d = wr_fire;
   end

   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign bus.fifo_write = wr_fire;
   assign bus.fifo_wdata = gnt[1] ? bus.req1_data : bus.req0_data;

   drain_state_e        state_q, state_d;
   logic                fifo_read_q, fifo_read_d;
   logic                tx_start_q, tx_start_d;
   logic                sched_busy_q, sched_busy_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [15:0]         tx_count_q, tx_count_d;
   logic [7:0]          gap_cnt_q, gap_cnt_d;

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_count_d = tx_count_q;
      gap_cnt_d  = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.enable && !bus.fifo_status[STAT_EMPTY] && !bus.tx_busy) begin
               state_d = ST_READ;
            end
         end
         ST_READ:  state_d = ST_LOAD;
         ST_LOAD: begin
            tx_data_d = bus.fifo_rdata;
            state_d   = ST_START;
         end
         ST_START: begin
            tx_count_d = tx_count_q + 16'd1;
            state_d    = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (GAP_EN) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // strobes are registered from the next state so they never glitch
      fifo_read_d  = (state_d == ST_READ);
      tx_start_d   = (state_d == ST_START);
      sched_busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         fifo_read_q  <= 1'b0;
         tx_start_q   <= 1'b0;
         sched_busy_q <= 1'b0;
         tx_data_q    <= '0;
         tx_count_q   <= 16'd0;
         gap_cnt_q    <= 8'd0;
         wr_prev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fifo_read_q  <= fifo_read_d;
         tx_start_q   <= tx_start_d;
         sched_busy_q <= sched_busy_d;
         tx_data_q    <= tx_data_d;
         tx_count_q   <= tx_count_d;
         gap_cnt_q    <= gap_cnt_d;
         wr_prev_q    <= wr_prev_d;
      end
   end

   assign bus.fifo_read  = fifo_read_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.sched_busy = sched_busy_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.tx_count   = tx_count_q;

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Bench for fifo_tx_scheduler: two instances (no gap, 3-cycle gap) with a queue FIFO and a fixed-length transmitter model.
module tb_fifo_tx_scheduler;

   localparam int BUSY_LEN = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_tx_scheduler_if ia ();
   fifo_tx_scheduler_if ib ();

   fifo_tx_scheduler #(.GAP_CYCLES(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   fifo_tx_scheduler #(.GAP_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   bit         drain_a = 1'b0;
   bit         drain_b = 1'b0;
   int         bcnt_a  = 0;
   int         bcnt_b  = 0;

   int         rd_a[$], st_a[$], bf_a[$], sf_a[$];
   int         rd_b[$], st_b[$], bf_b[$], sf_b[$];
   logic [7:0] sd_a[$], sd_b[$];
   bit         pb_a, ps_a, pb_b, ps_b;

   // reference arbitration state: who won last, and whether a write happened last cycle
   bit m_last = 1'b1;
   bit m_prev = 1'b0;

   function automatic logic [3:0] fstat(input int n);
      fstat    = 4'b0000;
      fstat[0] = (n == 0);
      fstat[3] = (n <= 1);
   endfunction

   // FIFO and transmitter behaviour, updated shortly after each rising edge
   always @(posedge clk) begin
      #2;
      if (drain_a) begin
         if (ia.fifo_read && q_a.size() > 0) ia.fifo_rdata = q_a.pop_front();
         ia.fifo_status = fstat(q_a.size());
      end
      if (drain_b) begin
         if (ib.fifo_read && q_b.size() > 0) ib.fifo_rdata = q_b.pop_front();
         ib.fifo_status = fstat(q_b.size());
      end
      if (ia.tx_start) begin
         bcnt_a = BUSY_LEN; ia.tx_busy = 1'b1;
      end else if (bcnt_a > 0) begin
         bcnt_a--; ia.tx_busy = (bcnt_a > 0);
      end
      if (ib.tx_start) begin
         bcnt_b = BUSY_LEN; ib.tx_busy = 1'b1;
      end else if (bcnt_b > 0) begin
         bcnt_b--; ib.tx_busy = (bcnt_b > 0);
      end
   end

   // event log, stamped with the cycle number at each falling edge
   always @(negedge clk) begin
      cyc++;
      if (ia.fifo_read) rd_a.push_back(cyc);
      if (ia.tx_start) begin st_a.push_back(cyc); sd_a.push_back(ia.tx_data); end
      if (pb_a && !ia.tx_busy) bf_a.push_back(cyc);
      if (ps_a && !ia.sched_busy) sf_a.push_back(cyc);
      pb_a = ia.tx_busy; ps_a = ia.sched_busy;
      if (ib.fifo_read) rd_b.push_back(cyc);
      if (ib.tx_start) begin st_b.push_back(cyc); sd_b.push_back(ib.tx_data); end
      if (pb_b && !ib.tx_busy) bf_b.push_back(cyc);
      if (ps_b && !ib.sched_busy) sf_b.push_back(cyc);
      pb_b = ib.tx_busy; ps_b = ib.sched_busy;
   end

   task automatic clear_logs();
      rd_a.delete(); st_a.delete(); bf_a.delete(); sf_a.delete(); sd_a.delete();
      rd_b.delete(); st_b.delete(); bf_b.delete(); sf_b.delete(); sd_b.delete();
   endtask

   // Called just after a falling edge: drives one write-side cycle on instance a, checks it
   // against the reference arbitration rules, and returns at the next falling edge.
   task automatic drive_write_cycle(input bit v0, input bit v1, input logic [7:0] d0,
                                    input logic [7:0] d1, input logic [3:0] st, output int obs_w);
      int g;
      bit blk, ew;
      ia.req0_valid = v0; ia.req1_valid = v1;
      ia.req0_data = d0;  ia.req1_data = d1;
      ia.fifo_status = st;
      #1;
      g = -1;
      if (v0 && v1) g = m_last ? 0 : 1;
      else if (v0) g = 0;
      else if (v1) g = 1;
      blk = st[1] || (st[2] && m_prev);
      ew  = (g >= 0) && !blk;
      obs_w = ia.req1_ready ? 1 : (ia.req0_ready ? 0 : -1);
      ntests++;
      if (ia.fifo_write !== ew || ia.req0_ready !== (ew && g == 0) || ia.req1_ready !== (ew && g == 1)) begin
         nfail++;
         $display("FAIL write_strobe: got write=%b rdy0=%b rdy1=%b, expected write=%b winner=%0d (v=%b%b st=%h)",
                  ia.fifo_write, ia.req0_ready, ia.req1_ready, ew, g, v1, v0, st);
      end
      if (ew) begin
         ntests++;
         if (ia.fifo_wdata !== (g == 1 ? d1 : d0)) begin
            nfail++;
            $display("FAIL write_data: got %h expected %h", ia.fifo_wdata, (g == 1 ? d1 : d0));
         end
         m_last = (g == 1);
      end
      m_prev = ew;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int w;
      ia.req0_valid = 1'b1; ia.req1_valid = 1'b1;
      ia.req0_data = 8'h11; ia.req1_data = 8'h22;
      ia.fifo_status = 4'h0; ia.fifo_rdata = 8'h00;
      ia.enable = 1'b0; ia.tx_busy = 1'b0;
      ib.req0_valid = 1'b0; ib.req1_valid = 1'b0;
      ib.req0_data = 8'h00; ib.req1_data = 8'h00;
      ib.fifo_status = 4'h1; ib.fifo_rdata = 8'h00;
      ib.enable = 1'b0; ib.tx_busy = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      ntests++;
      if ({ia.req0_ready, ia.req1_ready, ia.fifo_write} !== 3'b000) begin
         nfail++;
         $display("FAIL reset_ready: got rdy0/rdy1/write=%b%b%b expected 000", ia.req0_ready, ia.req1_ready, ia.fifo_write);
      end
      ntests++;
      if ({ia.fifo_read, ia.tx_start, ia.sched_busy} !== 3'b000) begin
         nfail++;
         $display("FAIL reset_strobes: got read/start/busy=%b%b%b expected 000", ia.fifo_read, ia.tx_start, ia.sched_busy);
      end
      ntests++;
      if (ia.tx_data !== 8'h00 || ia.tx_count !== 16'h0000 || ib.tx_count !== 16'h0000) begin
         nfail++;
         $display("FAIL reset_regs: got tx_data=%h tx_count=%h/%h expected 00 0000", ia.tx_data, ia.tx_count, ib.tx_count);
      end
      @(negedge clk);
      rst = 1'b0; m_last = 1'b1; m_prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_write_cycle(1'b1, 1'b1, 8'h10 + 8'(i), 8'h20 + 8'(i), 4'h0, w);
         ntests++;
         if (w != (i % 2)) begin
            nfail++;
            $display("FAIL reset_alternation: write %0d went to requester %0d expected %0d", i, w, i % 2);
         end
      end
   endtask

   task automatic test_full();
      int w, nwr;
      bit prev, back2back;
      drive_write_cycle(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, w);
      drive_write_cycle(1'b1, 1'b0, 8'h33, 8'h44, 4'h2, w);
      ntests++;
      if (w != -1) begin
         nfail++;
         $display("FAIL full_block: got winner %0d expected none", w);
      end
      drive_write_cycle(1'b1, 1'b1, 8'h35, 8'h46, 4'h6, w);
      nwr = 0; prev = 1'b0; back2back = 1'b0;
      drive_write_cycle(1'b0, 1'b0, 8'h00, 8'h00, 4'h4, w);
      for (int i = 0; i < 8; i++) begin
         drive_write_cycle(1'b1, 1'b1, 8'h50 + 8'(i), 8'h60 + 8'(i), 4'h4, w);
         if (w >= 0) begin
            nwr++;
            if (prev) back2back = 1'b1;
         end
         prev = (w >= 0);
      end
      ntests++;
      if (nwr != 4 || back2back) begin
         nfail++;
         $display("FAIL afull_rate: got %0d writes in 8 cycles (back-to-back=%b) expected 4 and none", nwr, back2back);
      end
   endtask

   task automatic test_random_writes();
      int w, r;
      logic [3:0] st;
      for (int i = 0; i < 60; i++) begin
         r  = $urandom_range(0, 7);
         st = 4'(($urandom_range(0, 1)) | (($urandom_range(0, 1)) << 3));
         if (r == 0) st[1] = 1'b1;
         if (r <= 3) st[2] = 1'b1;
         drive_write_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), st, w);
      end
      drive_write_cycle(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, w);
   endtask

   task automatic test_drain();
      clear_logs();
      q_a.delete(); q_a.push_back(8'h55); drain_a = 1'b1;
      @(negedge clk);
      ia.enable = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      ntests++;
      if (rd_a.size() != 1 || st_a.size() != 1) begin
         nfail++;
         $display("FAIL drain_counts: got %0d reads %0d starts expected 1 1", rd_a.size(), st_a.size());
      end else begin
         ntests++;
         if (st_a[0] - rd_a[0] != 2 || sd_a[0] !== 8'h55) begin
            nfail++;
            $display("FAIL drain_start: got start %0d cycles after read with data %h expected 2 and 55",
                     st_a[0] - rd_a[0], sd_a[0]);
         end
      end
      ntests++;
      if (ia.tx_count !== 16'd1 || ia.tx_data !== 8'h55) begin
         nfail++;
         $display("FAIL drain_count: got tx_count=%0d tx_data=%h expected 1 55", ia.tx_count, ia.tx_data);
      end
      ntests++;
      if (bf_a.size() != 1 || sf_a.size() != 1 || sf_a[0] - bf_a[0] != 1) begin
         nfail++;
         $display("FAIL drain_busy_fall: got %0d busy falls %0d sched falls expected sched_busy to fall 1 cycle after tx_busy",
                  bf_a.size(), sf_a.size());
      end
      ia.enable = 1'b0;
   endtask

   task automatic test_gap();
      clear_logs();
      q_a.push_back(8'hA1); q_a.push_back(8'hA2);
      q_b.delete(); q_b.push_back(8'hB1); q_b.push_back(8'hB2);
      drain_b = 1'b1;
      @(negedge clk);
      ia.enable = 1'b1; ib.enable = 1'b1;
      repeat (60) @(negedge clk);
      #1;
      ntests++;
      if (rd_b.size() != 2 || st_b.size() != 2 || bf_b.size() < 1 || sf_b.size() < 1) begin
         nfail++;
         $display("FAIL gap_counts: got %0d reads %0d starts expected 2 2", rd_b.size(), st_b.size());
      end else begin
         ntests++;
         if (rd_b[1] - bf_b[0] != 5 || sf_b[0] - bf_b[0] != 4) begin
            nfail++;
            $display("FAIL gap_timing: got read2 %0d and idle %0d cycles after busy fall expected 5 and 4",
                     rd_b[1] - bf_b[0], sf_b[0] - bf_b[0]);
         end
         ntests++;
         if (sd_b[0] !== 8'hB1 || sd_b[1] !== 8'hB2 || ib.tx_count !== 16'd2) begin
            nfail++;
            $display("FAIL gap_data: got %h %h count %0d expected b1 b2 2", sd_b[0], sd_b[1], ib.tx_count);
         end
      end
      ntests++;
      if (rd_a.size() != 2 || bf_a.size() < 1 || rd_a[1] - bf_a[0] != 2) begin
         nfail++;
         $display("FAIL nogap_timing: got %0d reads, second read not 2 cycles after busy fall", rd_a.size());
      end
      ntests++;
      if (sd_a.size() != 2 || sd_a[0] !== 8'hA1 || sd_a[1] !== 8'hA2 || ia.tx_count !== 16'd3) begin
         nfail++;
         $display("FAIL nogap_data: got %0d bytes count %0d expected a1 a2 and count 3", sd_a.size(), ia.tx_count);
      end
      ia.enable = 1'b0; ib.enable = 1'b0;
   endtask

   task automatic test_enable();
      clear_logs();
      q_a.push_back(8'hC1); q_a.push_back(8'hC2);
      @(negedge clk);
      ia.enable = 1'b1;
      for (int i = 0; i < 30 && st_a.size() == 0; i++) begin
         @(negedge clk); #1;
      end
      ntests++;
      if (st_a.size() == 0) begin
         nfail++;
         $display("FAIL enable_first_start: no tx_start within 30 cycles expected one");
         ia.enable = 1'b0;
         return;
      end
      @(negedge clk);
      ia.enable = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      ntests++;
      if (rd_a.size() != 1 || st_a.size() != 1 || ia.tx_count !== 16'd4 || ia.sched_busy !== 1'b0) begin
         nfail++;
         $display("FAIL enable_halt: got %0d reads %0d starts count %0d busy %b expected 1 1 4 0",
                  rd_a.size(), st_a.size(), ia.tx_count, ia.sched_busy);
      end
      ia.enable = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      ntests++;
      if (rd_a.size() != 2 || sd_a.size() != 2 || sd_a[1] !== 8'hC2) begin
         nfail++;
         $display("FAIL enable_resume: got %0d reads %0d bytes expected 2 with second byte c2", rd_a.size(), sd_a.size());
      end
   endtask

   task automatic test_reset_in_load();
      int w;
      clear_logs();
      q_a.push_back(8'hD1);
      for (int i = 0; i < 30 && rd_a.size() == 0; i++) begin
         @(negedge clk); #1;
      end
      ntests++;
      if (rd_a.size() == 0) begin
         nfail++;
         $display("FAIL load_reset_read: no fifo_read within 30 cycles expected one");
      end
      @(negedge clk);
      rst = 1'b1;
      q_a.delete(); bcnt_a = 0; ia.tx_busy = 1'b0;
      #1;
      ntests++;
      if ({ia.tx_start, ia.sched_busy, ia.fifo_read} !== 3'b000 || ia.tx_count !== 16'd0) begin
         nfail++;
         $display("FAIL load_reset_now: got start/busy/read=%b%b%b count %0d expected 000 0",
                  ia.tx_start, ia.sched_busy, ia.fifo_read, ia.tx_count);
      end
      @(negedge clk);
      rst = 1'b0; m_last = 1'b1; m_prev = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      ntests++;
      if (st_a.size() != 0 || ia.tx_count !== 16'd0 || ia.tx_data !== 8'h00) begin
         nfail++;
         $display("FAIL load_reset_drop: got %0d starts count %0d data %h expected 0 0 00",
                  st_a.size(), ia.tx_count, ia.tx_data);
      end
      ia.enable = 1'b0; drain_a = 1'b0;
      @(negedge clk);
      drive_write_cycle(1'b1, 1'b1, 8'h5A, 8'hA5, 4'h0, w);
      ntests++;
      if (w != 0) begin
         nfail++;
         $display("FAIL load_reset_tie: first tie after reset went to %0d expected 0", w);
      end
      drive_write_cycle(1'b0, 1'b0, 8'h00, 8'h00, 4'h1, w);
   endtask

   task automatic test_wrap();
      clear_logs();
      q_a.delete(); drain_a = 1'b1;
      @(negedge clk);
      force dut_a.tx_count_q = 16'hFFFF;
      @(negedge clk);
      release dut_a.tx_count_q;
      q_a.push_back(8'hE7);
      @(negedge clk);
      ia.enable = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      ntests++;
      if (st_a.size() != 1 || ia.tx_count !== 16'd0 || ia.tx_data !== 8'hE7) begin
         nfail++;
         $display("FAIL wrap: got %0d starts count %h data %h expected 1 0000 e7", st_a.size(), ia.tx_count, ia.tx_data);
      end
      ia.enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full();
      test_random_writes();
      test_drain();
      test_gap();
      test_enable();
      test_reset_in_load();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
